// File: rtl/soda_dispense_ctrl.sv
// Can-release controller: queues vend drops, runs the motor, confirms with the chute sensor.
// Optional SODA_VEND_COUNT_EN adds a 16-bit confirmed-vend counter with synchronous clear.
module soda_dispense_ctrl #(
   parameter int unsigned STOCK_W      = 4,
   parameter int unsigned PEND_W       = 2,
   parameter int unsigned MOTOR_CYCLES = 8,
   parameter int unsigned TIMEOUT      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               drop,
   input  logic               can_sense,
   input  logic               restock,
   input  logic [STOCK_W-1:0] restock_qty,
   input  logic               clear_fault,
`ifdef SODA_VEND_COUNT_EN
   input  logic               count_clear,
   output logic [15:0]        vend_count,
`endif
   output logic               motor,
   output logic               vend_done,
   output logic               refund,
   output logic               fault,
   output logic               sold_out,
   output logic               busy,
   output logic [STOCK_W-1:0] stock,
   output logic [PEND_W-1:0]  pending
);

   localparam int unsigned TIMER_MAX = (MOTOR_CYCLES > TIMEOUT) ? MOTOR_CYCLES : TIMEOUT;
   localparam int unsigned TIMER_W   = (TIMER_MAX > 1) ? $clog2(TIMER_MAX) : 1;
   localparam int unsigned CMP_W     = (STOCK_W > PEND_W) ? STOCK_W : PEND_W;

   localparam logic [TIMER_W-1:0] MOTOR_LOAD  = TIMER_W'(MOTOR_CYCLES - 1);
   localparam logic [TIMER_W-1:0] SENSE_LOAD  = TIMER_W'(TIMEOUT - 1);
   localparam logic [PEND_W-1:0]  PEND_MAX    = '1;
   localparam logic [STOCK_W-1:0] STOCK_MAX   = '1;
   localparam logic [STOCK_W:0]   STOCK_MAX_W = {1'b0, STOCK_MAX};

   typedef enum logic [1:0] {StIdle, StMotor, StSense, StFault} state_e;

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic                 done;

   logic [PEND_W-1:0]    pending_q, pending_d;
   logic [STOCK_W-1:0]   stock_q, stock_d;
   logic [STOCK_W:0]     stock_sum;
   logic [CMP_W-1:0]     pend_ext, stock_ext;
   logic                 accept;

   logic                 motor_q, motor_d;
   logic                 busy_q, busy_d;
   logic                 fault_q, fault_d;
   logic                 vend_done_q, refund_q, sold_out_q;

   // ---------------------------------------------------------------- state register
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      done    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (pending_q != '0 && stock_q != '0) begin
               state_d = StMotor;
               timer_d = MOTOR_LOAD;
            end
         end
         StMotor: begin
            if (timer_q == '0) begin
               state_d = StSense;
               timer_d = SENSE_LOAD;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StSense: begin
            if (can_sense) begin
               done    = 1'b1;
               state_d = StIdle;
            end else if (timer_q == '0) begin
               state_d = StFault;
            end else begin
               timer_d = timer_q - 1'b1;
            end
         end
         StFault: begin
            if (clear_fault) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // ---------------------------------------------------------------- outputs (from next state)
   always_comb begin
      motor_d = 1'b0;
      busy_d  = 1'b0;
      fault_d = 1'b0;
      unique case (state_d)
         StMotor: begin
            motor_d = 1'b1;
            busy_d  = 1'b1;
         end
         StSense: busy_d  = 1'b1;
         StFault: fault_d = 1'b1;
         default: ;
      endcase
   end

   // ---------------------------------------------------------------- queue and stock
   assign pend_ext  = CMP_W'(pending_q);
   assign stock_ext = CMP_W'(stock_q);

   // Acceptance looks only at pre-update counts, so a drop racing a done is judged on old stock.
   assign accept = drop && (pending_q != PEND_MAX) && (pend_ext < stock_ext);

   always_comb begin
      pending_d = pending_q;
      if (accept && !done) begin
         pending_d = pending_q + 1'b1;
      end else if (!accept && done) begin
         pending_d = pending_q - 1'b1;
      end
   end

   // One extra bit so restock overflow can be detected and clamped.
   always_comb begin
      stock_sum = {1'b0, stock_q} + (restock ? {1'b0, restock_qty} : '0)
                  - {{STOCK_W{1'b0}}, done};
      stock_d   = (stock_sum > STOCK_MAX_W) ? STOCK_MAX : stock_sum[STOCK_W-1:0];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pending_q   <= '0;
         stock_q     <= '0;
         motor_q     <= 1'b0;
         busy_q      <= 1'b0;
         fault_q     <= 1'b0;
         vend_done_q <= 1'b0;
         refund_q    <= 1'b0;
         sold_out_q  <= 1'b1;
      end else begin
         pending_q   <= pending_d;
         stock_q     <= stock_d;
         motor_q     <= motor_d;
         busy_q      <= busy_d;
         fault_q     <= fault_d;
         vend_done_q <= done;
         refund_q    <= drop && !accept;
         sold_out_q  <= (stock_d == '0);
      end
   end

`ifdef SODA_VEND_COUNT_EN
   logic [15:0] vend_count_q;

   always_ff @(posedge clock) begin
      if (reset || count_clear) begin
         vend_count_q <= '0;
      end else if (done) begin
         vend_count_q <= vend_count_q + 16'd1;
      end
   end

   assign vend_count = vend_count_q;
`endif

   assign motor     = motor_q;
   assign busy      = busy_q;
   assign fault     = fault_q;
   assign vend_done = vend_done_q;
   assign refund    = refund_q;
   assign sold_out  = sold_out_q;
   assign stock     = stock_q;
   assign pending   = pending_q;

   motor_not_in_fault: assert property (@(posedge clock) disable iff (reset) !(motor_q && fault_q));

endmodule

// File: doc/soda_dispense_ctrl.md
Name: soda_dispense_ctrl

Overview:
- Downstream stage of the coin/credit vending FSM.
- Consumes its one-cycle `drop` pulses, queues them, and drives the can-release motor for a fixed time.
- Confirms each vend with a chute sensor, tracks on-board stock, and refunds drops it cannot honour.
- Raises a latched fault if the sensor never confirms a vend.

Parameters:
STOCK_W, 4, width of stock counter; STOCK_MAX = 2**STOCK_W-1
PEND_W, 2, width of pending-vend counter; PEND_MAX = 2**PEND_W-1
MOTOR_CYCLES, 8, cycles motor is held on per vend (>=1)
TIMEOUT, 16, cycles allowed after motor-off for sensor confirm (>=1)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
drop  input  1  one-cycle vend request from credit FSM
can_sense  input  1  chute sensor, high when a can passes (already synchronized)
restock  input  1  one-cycle pulse: add restock_qty to stock
restock_qty  input  STOCK_W  cans added on restock
clear_fault  input  1  one-cycle pulse: leave FAULT
motor  output  1  release motor enable
vend_done  output  1  one-cycle pulse on confirmed vend
refund  output  1  one-cycle pulse: drop rejected
fault  output  1  high while in FAULT
sold_out  output  1  high when stock == 0
busy  output  1  high in MOTOR or SENSE
stock  output  STOCK_W  cans in machine
pending  output  PEND_W  accepted, not-yet-completed vends

Behaviour:
- All outputs registered.
- Reset values: state IDLE, stock=0, pending=0, and motor, vend_done, refund, fault, busy all 0. sold_out=1 because stock is 0.
- Reset mid-vend aborts immediately. Motor drops the cycle after reset is sampled. The queue is lost.
- Drop acceptance, evaluated on pre-update values of the same cycle:
  - Accept if pending < PEND_MAX and pending < stock.
  - Otherwise reject and assert refund for exactly one cycle, in the cycle after the drop.
  - Acceptance is allowed in any state, including FAULT.
- Pending update: pending_next = pending + accept - done, where done is the vend_done event of this cycle.
- Stock update: stock_next = min(stock + (restock ? restock_qty : 0) - done, STOCK_MAX).
  - Computed at width STOCK_W+1, then saturated.
  - restock_qty=0 is a no-op.
- FSM:
  - IDLE:
    - If pending>0 and stock>0: go to MOTOR, load timer=MOTOR_CYCLES-1.
    - Motor is 1 from the next cycle.
    - With idle start, motor rises 2 cycles after the drop pulse.
  - MOTOR:
    - motor=1, busy=1.
    - Timer counts down; motor is high for exactly MOTOR_CYCLES cycles.
    - At timer==0: go to SENSE, load timer=TIMEOUT-1.
    - can_sense is ignored in MOTOR.
  - SENSE:
    - motor=0, busy=1.
    - If can_sense=1: done event; pulse vend_done next cycle; decrement pending and stock; go to IDLE.
    - Else if timer==0: go to FAULT.
    - Else decrement the timer.
  - FAULT:
    - fault=1, motor=0, busy=0.
    - Pending and stock are retained.
    - clear_fault returns to IDLE, which then retries a queued vend.
    - clear_fault outside FAULT is ignored.
- Back-to-back vends: after a done event, IDLE is spent for one cycle before the next MOTOR. Minimum period is MOTOR_CYCLES + 2 + sense delay.
- A stray can_sense in IDLE or FAULT is ignored.
- sold_out = (stock == 0), registered with stock.

Optional Feature:
- Macro: SODA_VEND_COUNT_EN.
- When defined:
  - Adds output port vend_count, 16 bits.
  - Increments by 1 on each done event.
  - Wraps 0xFFFF -> 0x0000.
  - Reset to 0.
  - Adds input count_clear, 1 bit, which zeroes the counter next cycle. If count_clear coincides with a done event, clear wins.
- When undefined: neither port exists and behaviour is otherwise identical.

Test Plan:
- Reset, then drop with stock=0 -> refund=1 one cycle later; pending=0; motor never rises; sold_out=1.
- restock qty=3, drop at cycle N, can_sense 2 cycles into SENSE -> motor high cycles N+2..N+9 (8 cycles); vend_done one cycle; stock=2; pending=0.
- stock=5, four drops with no can_sense -> pending saturates at 3 and the 4th drop refunds. After TIMEOUT=16 cycles fault=1, pending=3. clear_fault -> motor restarts.
- stock=15, restock qty=4 -> stock=15 (saturate). restock qty=2 coincident with a done event at stock=14 -> stock=15.
- pending=stock=1, drop coincident with done event -> drop refunded; pending=0; stock=0; sold_out=1.
- reset asserted mid-MOTOR -> motor=0 next cycle and all counters 0. With SODA_VEND_COUNT_EN defined, 3 vends -> vend_count=3; count_clear -> 0.
